// File: rtl/pkg_mic_serial.sv
// Shared state type and default parameters for the microphone LED serial transmitter.
package pkg_mic_serial;

    localparam int unsigned DefWordWidth   = 32;
    localparam int unsigned DefHalfPeriod  = 4;
    localparam int unsigned DefQueueDepth  = 4;
    localparam int unsigned DefLatchCycles = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } mic_serial_state_t;

endpackage

// File: rtl/mic_serial_queue.sv
// Single-clock FIFO holding words waiting to be shifted out; pop data is read combinationally.
module mic_serial_queue
    import pkg_mic_serial::*;
#(
    parameter int unsigned WIDTH = DefWordWidth,
    parameter int unsigned DEPTH = DefQueueDepth
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [AddrW:0] LevelFull = (AddrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   level_q, level_d;
    logic             push_en, pop_en;

    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign push_ready = (level_q != LevelFull);
    assign empty      = (level_q == '0);
    assign push_en    = push_valid && push_ready;
    assign pop_en     = pop && !empty;
    assign pop_data   = mem_q[rd_ptr_q];
    assign level      = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + (AddrW + 1)'(1);
            2'b01:   level_d = level_q - (AddrW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mic_serial_tx.sv
// Queued MSB-first serial transmitter: data/clock pair plus an end-of-word latch strobe.
module mic_serial_tx
    import pkg_mic_serial::*;
#(
    parameter int unsigned WORD_WIDTH   = DefWordWidth,
    parameter int unsigned HALF_PERIOD  = DefHalfPeriod,
    parameter int unsigned QUEUE_DEPTH  = DefQueueDepth,
    parameter int unsigned LATCH_CYCLES = DefLatchCycles
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         word_valid,
    input  logic [WORD_WIDTH-1:0]        word_data,
    output logic                         word_ready,
    output logic                         overflow,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level,
    output logic                         busy,
    output logic                         sdo,
    output logic                         sck,
    output logic                         latch
);

    localparam int unsigned BitW   = $clog2(WORD_WIDTH);
    localparam int unsigned PhaseW = $clog2(2 * HALF_PERIOD);
    localparam int unsigned LatchW = $clog2(LATCH_CYCLES + 1);

    localparam logic [BitW-1:0]   BitLast    = BitW'(WORD_WIDTH - 1);
    localparam logic [PhaseW-1:0] PhaseHigh  = PhaseW'(HALF_PERIOD);
    localparam logic [PhaseW-1:0] PhaseLast  = PhaseW'(2 * HALF_PERIOD - 1);
    localparam logic [LatchW-1:0] LatchFirst = LatchW'(LATCH_CYCLES - 1);

    mic_serial_state_t state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PhaseW-1:0]     phase_cnt_q, phase_cnt_d;
    logic [LatchW-1:0]     latch_cnt_q, latch_cnt_d;
    logic                  sdo_q, sdo_d;
    logic                  sck_q, sck_d;
    logic                  latch_q, latch_d;
    logic                  overflow_q, overflow_d;

    logic                  q_pop;
    logic [WORD_WIDTH-1:0] q_pop_data;
    logic                  q_empty;

    mic_serial_queue #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (word_valid),
        .push_data  (word_data),
        .push_ready (word_ready),
        .pop        (q_pop),
        .pop_data   (q_pop_data),
        .empty      (q_empty),
        .level      (queue_level)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        phase_cnt_d = phase_cnt_q;
        latch_cnt_d = latch_cnt_q;
        q_pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    q_pop       = 1'b1;
                    shreg_d     = q_pop_data;
                    bit_cnt_d   = BitLast;
                    phase_cnt_d = '0;
                    state_d     = StShift;
                end
            end
            StShift: begin
                // Data advances only at the end of the high phase, i.e. on the sck falling edge.
                if (phase_cnt_q == PhaseLast) begin
                    if (bit_cnt_q == '0) begin
                        latch_cnt_d = LatchFirst;
                        state_d     = StLatch;
                    end else begin
                        shreg_d     = shreg_q << 1;
                        bit_cnt_d   = bit_cnt_q - BitW'(1);
                        phase_cnt_d = '0;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + PhaseW'(1);
                end
            end
            StLatch: begin
                if (latch_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    latch_cnt_d = latch_cnt_q - LatchW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are derived from next-state values so the pins are flop outputs.
        sdo_d      = (state_d == StShift) && shreg_d[WORD_WIDTH-1];
        sck_d      = (state_d == StShift) && (phase_cnt_d >= PhaseHigh);
        latch_d    = (state_d == StLatch);
        overflow_d = word_valid && !word_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            phase_cnt_q <= '0;
            latch_cnt_q <= '0;
            sdo_q       <= 1'b0;
            sck_q       <= 1'b0;
            latch_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            sdo_q       <= sdo_d;
            sck_q       <= sck_d;
            latch_q     <= latch_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sdo      = sdo_q;
    assign sck      = sck_q;
    assign latch    = latch_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) || (queue_level != '0);

endmodule

// File: tb/tb_mic_serial_tx.sv
// Directed self-checking bench for mic_serial_tx: default instance plus a fast-timing instance.
module tb_mic_serial_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_ready, overflow, busy, sdo, sck, latch;
    logic [2:0]  queue_level;

    logic        v2 = 1'b0;
    logic [31:0] d2 = '0;
    logic        r2, o2, b2, sdo2, sck2, l2;
    logic [2:0]  ql2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mic_serial_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .overflow    (overflow),
        .queue_level (queue_level),
        .busy        (busy),
        .sdo         (sdo),
        .sck         (sck),
        .latch       (latch)
    );

    mic_serial_tx #(
        .WORD_WIDTH   (32),
        .HALF_PERIOD  (1),
        .QUEUE_DEPTH  (4),
        .LATCH_CYCLES (1)
    ) dut_fast (
        .clk         (clk),
        .reset_n     (reset_n),
        .word_valid  (v2),
        .word_data   (d2),
        .word_ready  (r2),
        .overflow    (o2),
        .queue_level (ql2),
        .busy        (b2),
        .sdo         (sdo2),
        .sck         (sck2),
        .latch       (l2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows one default-instance word from just after its accept edge until busy drops.
    task automatic watch(output int cycles, output int rises, output int latch_hi,
                         output int bad_edges, output logic [31:0] bits);
        logic prev_sck, prev_sdo;
        cycles = 0; rises = 0; latch_hi = 0; bad_edges = 0; bits = '0;
        prev_sck = sck; prev_sdo = sdo;
        do begin
            step();
            cycles++;
            if (!prev_sck && sck) begin
                rises++;
                bits = {bits[30:0], sdo};
            end
            if (latch) latch_hi++;
            if (sdo != prev_sdo && !(prev_sck && !sck) && cycles != 1) bad_edges++;
            prev_sck = sck;
            prev_sdo = sdo;
        end while (busy && cycles < 1000);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck); end
        n_checks++; if (latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b want 0", latch); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_checks++;
        if (queue_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", queue_level); end
        n_checks++;
        if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", word_ready); end
        n_checks++; if (b2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_fast: got %b want 0", b2); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int cyc, rs, lh, bad;
        logic [31:0] bits;
        word_valid = 1'b1; word_data = 32'h8000_0001;
        step();
        word_valid = 1'b0;
        n_checks++;
        if (queue_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", queue_level); end
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL single_sdo_pre: got %b want 0", sdo); end
        watch(cyc, rs, lh, bad, bits);
        n_checks++; if (cyc != 265) begin n_fail++; $display("FAIL single_busy_len: got %0d want 265", cyc); end
        n_checks++; if (rs != 32) begin n_fail++; $display("FAIL single_rises: got %0d want 32", rs); end
        n_checks++; if (lh != 8) begin n_fail++; $display("FAIL single_latch_len: got %0d want 8", lh); end
        n_checks++;
        if (bits !== 32'h8000_0001) begin n_fail++; $display("FAIL single_bits: got %h want 80000001", bits); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_sdo_edges: got %0d want 0", bad); end
    endtask

    task automatic test_pattern();
        int cyc, rs, lh, bad;
        logic [31:0] bits;
        word_valid = 1'b1; word_data = 32'hA5A5_5A5A;
        step();
        word_valid = 1'b0;
        watch(cyc, rs, lh, bad, bits);
        n_checks++;
        if (bits !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL pattern_bits: got %h want a5a55a5a", bits); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pattern_sdo_edges: got %0d want 0", bad); end
        n_checks++; if (rs != 32) begin n_fail++; $display("FAIL pattern_rises: got %0d want 32", rs); end
        n_checks++; if (cyc != 265) begin n_fail++; $display("FAIL pattern_busy_len: got %0d want 265", cyc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [6];
        logic [31:0] rx [5];
        int lrise [5];
        int rises = 0, ovf = 0, nl = 0, n;
        logic prev_sck = 1'b0, prev_latch = 1'b0;
        w = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h8421_1248,
              32'hDEAD_BEEF};
        for (n = 0; n < 2000; n++) begin
            if (n < 6) begin word_valid = 1'b1; word_data = w[n]; end
            else word_valid = 1'b0;
            step();
            if (overflow) ovf++;
            if (!prev_sck && sck) begin
                if (rises < 160) rx[rises / 32] = {rx[rises / 32][30:0], sdo};
                rises++;
            end
            if (!prev_latch && latch) begin
                if (nl < 5) lrise[nl] = n;
                nl++;
            end
            prev_sck = sck;
            prev_latch = latch;
            if (n == 0) begin
                n_checks++;
                if (queue_level !== 3'd1) begin n_fail++; $display("FAIL b2b_lvl0: got %0d want 1", queue_level); end
            end
            if (n == 1) begin
                n_checks++;
                if (queue_level !== 3'd1) begin n_fail++; $display("FAIL b2b_lvl1: got %0d want 1", queue_level); end
                n_checks++;
                if (sdo !== w[0][31]) begin n_fail++; $display("FAIL b2b_load_msb: got %b want %b", sdo, w[0][31]); end
            end
            if (n == 4) begin
                n_checks++;
                if (queue_level !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got %0d want 4", queue_level); end
                n_checks++;
                if (word_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b want 0", word_ready); end
            end
            if (n == 5) begin
                n_checks++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf: got %b want 1", overflow); end
                n_checks++;
                if (queue_level !== 3'd4) begin n_fail++; $display("FAIL b2b_lvl5: got %0d want 4", queue_level); end
            end
            if (n > 6 && !busy) break;
        end
        n_checks++; if (n != 1325) begin n_fail++; $display("FAIL b2b_busy_end: got %0d want 1325", n); end
        n_checks++; if (ovf != 1) begin n_fail++; $display("FAIL b2b_ovf_count: got %0d want 1", ovf); end
        n_checks++; if (rises != 160) begin n_fail++; $display("FAIL b2b_rises: got %0d want 160", rises); end
        n_checks++; if (nl != 5) begin n_fail++; $display("FAIL b2b_latches: got %0d want 5", nl); end
        for (int j = 0; j < 5 && j < nl; j++) begin
            n_checks++;
            if (rx[j] !== w[j]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", j, rx[j], w[j]); end
            if (j > 0) begin
                n_checks++;
                if (lrise[j] - lrise[j-1] != 265) begin
                    n_fail++;
                    $display("FAIL b2b_period%0d: got %0d want 265", j, lrise[j] - lrise[j-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, rs, lh, bad;
        logic [31:0] bits;
        word_valid = 1'b1; word_data = 32'hFFFF_FFFF;
        step();
        step();
        word_valid = 1'b0;
        repeat (173) step();
        n_checks++; if (sck !== 1'b1) begin n_fail++; $display("FAIL mid_pre_sck: got %b want 1", sck); end
        n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL mid_pre_sdo: got %b want 1", sdo); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL mid_sdo: got %b want 0", sdo); end
        n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL mid_sck: got %b want 0", sck); end
        n_checks++; if (latch !== 1'b0) begin n_fail++; $display("FAIL mid_latch: got %b want 0", latch); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++;
        if (queue_level !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", queue_level); end
        n_checks++;
        if (word_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", word_ready); end
        step();
        reset_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_rel: got %b want 0", busy); end
        word_valid = 1'b1; word_data = 32'h1234_5678;
        step();
        word_valid = 1'b0;
        watch(cyc, rs, lh, bad, bits);
        n_checks++;
        if (bits !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_after_bits: got %h want 12345678", bits); end
        n_checks++; if (cyc != 265) begin n_fail++; $display("FAIL mid_after_len: got %0d want 265", cyc); end
        n_checks++; if (lh != 8) begin n_fail++; $display("FAIL mid_after_latch: got %0d want 8", lh); end
    endtask

    task automatic test_full_pop();
        word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            word_data = 32'hC000_0000 + i;
            step();
        end
        word_valid = 1'b0;
        n_checks++;
        if (queue_level !== 3'd4) begin n_fail++; $display("FAIL fp_full: got %0d want 4", queue_level); end
        repeat (261) step();
        n_checks++; if (latch !== 1'b0) begin n_fail++; $display("FAIL fp_idle_latch: got %b want 0", latch); end
        n_checks++;
        if (word_ready !== 1'b0) begin n_fail++; $display("FAIL fp_ready: got %b want 0", word_ready); end
        word_valid = 1'b1; word_data = 32'hDEAD_BEEF;
        step();
        word_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fp_ovf: got %b want 1", overflow); end
        n_checks++;
        if (queue_level !== 3'd3) begin n_fail++; $display("FAIL fp_level: got %0d want 3", queue_level); end
        n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL fp_load_msb: got %b want 1", sdo); end
        step();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf_end: got %b want 0", overflow); end
    endtask

    task automatic test_fast();
        logic [31:0] w [2];
        logic [31:0] rx [2];
        int lrise [2];
        int rises = 0, nl = 0, notog = 0, lhi = 0, n;
        logic prev_sck, prev_latch;
        w = '{32'h8000_0001, 32'h5555_AAAA};
        v2 = 1'b1; d2 = w[0];
        step();
        d2 = w[1];
        step();
        v2 = 1'b0;
        n_checks++; if (ql2 !== 3'd1) begin n_fail++; $display("FAIL fast_level: got %0d want 1", ql2); end
        prev_sck = sck2; prev_latch = l2;
        for (n = 2; n < 400; n++) begin
            step();
            if (n <= 64 && sck2 == prev_sck) notog++;
            if (!prev_sck && sck2) begin
                if (rises < 64) rx[rises / 32] = {rx[rises / 32][30:0], sdo2};
                rises++;
            end
            if (!prev_latch && l2) begin
                if (nl < 2) lrise[nl] = n;
                nl++;
            end
            if (l2) lhi++;
            prev_sck = sck2;
            prev_latch = l2;
            if (!b2) break;
        end
        n_checks++; if (notog != 0) begin n_fail++; $display("FAIL fast_toggle: got %0d want 0", notog); end
        n_checks++; if (n != 132) begin n_fail++; $display("FAIL fast_busy_end: got %0d want 132", n); end
        n_checks++; if (nl != 2) begin n_fail++; $display("FAIL fast_latches: got %0d want 2", nl); end
        n_checks++; if (lhi != 2) begin n_fail++; $display("FAIL fast_latch_len: got %0d want 2", lhi); end
        if (nl == 2) begin
            n_checks++;
            if (lrise[1] - lrise[0] != 66) begin
                n_fail++;
                $display("FAIL fast_period: got %0d want 66", lrise[1] - lrise[0]);
            end
        end
        n_checks++; if (rises != 64) begin n_fail++; $display("FAIL fast_rises: got %0d want 64", rises); end
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (rx[j] !== w[j]) begin n_fail++; $display("FAIL fast_word%0d: got %h want %h", j, rx[j], w[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pattern();
        test_back_to_back();
        test_reset_mid();
        test_full_pop();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
